ireg_file_mp: RTL
=================

Name: ireg_file_mp

Overview:
Parametrised integer register file for the OSECPU core. It generalises the fixed 64x32, 2-read/1-write integer register file. Additions:
- configurable width, depth and read-port count
- two write ports with fixed priority
- same-cycle write-to-read bypass
- per-register pending scoreboard
- hardware clear sweep after reset or on request

The decode/issue stage reads operands and busy flags from it; the execute and memory stages write results back.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 6, address width; DEPTH = 2**ADDR_W registers
NRD, 2, number of read ports
ZERO_R0, 0, when 1: register 0 always reads 0, ignores writes, never busy

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
ready  out  1  high when the clear sweep is done and the file is usable
clr_req  in  1  one-cycle pulse; starts a full clear sweep
r_addr  in  NRD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
r_data  out  NRD*DATA_W  packed read data, combinational
r_busy  out  NRD  pending flag for each read address, combinational
wa_en  in  1  write port A enable (execute stage)
wa_addr  in  ADDR_W  write port A address
wa_data  in  DATA_W  write port A data
wb_en  in  1  write port B enable (memory stage); wins over A
wb_addr  in  ADDR_W  write port B address
wb_data  in  DATA_W  write port B data
rsv_en  in  1  reserve: mark rsv_addr pending
rsv_addr  in  ADDR_W  register to reserve

Behaviour:
- FSM has two states, CLEAR and RUN. A sweep counter cnt is ADDR_W bits wide.
- Reset (rst_n low, asynchronous):
  - state=CLEAR, cnt=0, ready=0, all busy bits 0.
  - Storage array is not reset asynchronously.
- CLEAR state:
  - Each rising edge writes mem[cnt]<=0 and increments cnt.
  - After writing DEPTH-1, state becomes RUN and ready=1.
  - ready rises exactly DEPTH rising edges after rst_n deasserts (64 with defaults).
  - wa_en, wb_en, rsv_en and clr_req are ignored.
  - r_data reads all zero; r_busy reads all zero.
- RUN state, writes on the rising edge:
  - wa_en: mem[wa_addr]<=wa_data. wb_en: mem[wb_addr]<=wb_data.
  - Both enabled to the same address: only wb_data is stored.
- RUN state, reads are combinational with bypass, per port k, first match wins:
  - wb_en and wb_addr==r_addr_k gives wb_data;
  - else wa_en and wa_addr==r_addr_k gives wa_data;
  - else mem[r_addr_k].
- Scoreboard:
  - A write on either port clears busy[addr] at the edge.
  - rsv_en sets busy[rsv_addr] at the edge.
  - Reserve and write to the same address in the same cycle leaves busy=1 (set wins).
  - r_busy_k = busy[r_addr_k] AND NOT (same-cycle write to r_addr_k on either port).
- ZERO_R0=1:
  - Address 0 reads 0 on every port with no bypass.
  - Writes to address 0 are dropped.
  - busy[0] is never set.
- clr_req in RUN:
  - Next edge: state=CLEAR, cnt=0, ready=0, all busy bits cleared.
  - Writes and reservations presented in the clr_req cycle are discarded.
- rst_n asserted mid-sweep: sweep restarts from cnt=0.
- Read ports are independent; any number may address the same register.
- No combinational path from r_addr to any stored state.

Test Plan:
- Reset release, defaults:
  - ready=0 for 63 edges; ready=1 after edge 64.
  - Before the sweep: preload via hierarchical force of mem[5]=0xDEAD. After ready=1: mem[5] reads 0.
  - wa_en held high during the sweep has no effect.
- Bypass and priority:
  - Cycle with wa(3,0x11) and wb(3,0x22), r_addr0=3: r_data0=0x22 in that cycle.
  - After the edge: r_data0 reads 0x22.
  - wa alone to 4 with value 0x33 and r_addr1=4: r_data1=0x33 combinationally.
- Scoreboard:
  - rsv 7: r_busy for reg 7 is 1 from the next cycle.
  - wa(7,0x5) that cycle: r_busy for reg 7 reads 0 and r_data shows 0x5.
  - Then rsv 7 and wb 7 in the same cycle: busy for reg 7 stays 1.
- clr_req: with regs 1..3 nonzero and reg 2 busy, pulse clr_req.
  - ready drops on the next edge.
  - 64 edges later ready=1, all registers read 0, all busy bits 0.
- Reset mid-sweep: assert rst_n low at sweep cycle 30 for 2 cycles.
  - ready rises exactly 64 edges after the second release.
- ZERO_R0=1, NRD=4, DATA_W=16:
  - wa(0,0xFFFF) and rsv 0: all ports addressing 0 read 0, r_busy=0.
  - Port 3 at address 9 after wb(9,0x1234) reads 0x1234.

Source files
------------

// File: rtl/ireg_file_mp.sv
// Parametrised integer register file: NRD combinational read ports with write bypass,
// two prioritised write ports, a pending scoreboard and a hardware clear sweep.
module ireg_file_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 6,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  input  logic                  clr_req,
  input  logic [NRD*ADDR_W-1:0] r_addr,
  output logic [NRD*DATA_W-1:0] r_data,
  output logic [NRD-1:0]        r_busy,
  input  logic                  wa_en,
  input  logic [ADDR_W-1:0]     wa_addr,
  input  logic [DATA_W-1:0]     wa_data,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [DEPTH-1:0]  busy, busy_nx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic run;
  logic wa_go, wb_go, rsv_go;
  logic [ADDR_W-1:0] ra;

  assign run   = (state == RUN);
  assign ready = run;

  // Effective write/reserve strobes: blocked while sweeping, during a clear request,
  // and for register 0 when it is hardwired to zero.
  assign wa_go  = run && !clr_req && wa_en  && !((ZERO_R0 != 0) && (wa_addr  == '0));
  assign wb_go  = run && !clr_req && wb_en  && !((ZERO_R0 != 0) && (wb_addr  == '0));
  assign rsv_go = run && !clr_req && rsv_en && !((ZERO_R0 != 0) && (rsv_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      busy  <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    busy_nx  = busy;
    case (state)
      CLEAR: begin
        cnt_nx  = cnt + 1'b1;
        busy_nx = '0;
        if (cnt == '1) state_nx = RUN;
      end
      RUN: begin
        if (clr_req) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
          busy_nx  = '0;
        end else begin
          // Reservation is applied last so it wins over a same-cycle write.
          if (wa_go)  busy_nx[wa_addr]  = 1'b0;
          if (wb_go)  busy_nx[wb_addr]  = 1'b0;
          if (rsv_go) busy_nx[rsv_addr] = 1'b1;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  // Storage has no reset; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt] <= '0;
    end else begin
      if (wa_go) mem[wa_addr] <= wa_data;
      if (wb_go) mem[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    r_data = '0;
    r_busy = '0;
    ra     = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = r_addr[k*ADDR_W +: ADDR_W];
      if (run && !((ZERO_R0 != 0) && (ra == '0))) begin
        if (wb_go && (wb_addr == ra))
          r_data[k*DATA_W +: DATA_W] = wb_data;
        else if (wa_go && (wa_addr == ra))
          r_data[k*DATA_W +: DATA_W] = wa_data;
        else
          r_data[k*DATA_W +: DATA_W] = mem[ra];
        r_busy[k] = busy[ra] && !(wa_go && (wa_addr == ra)) && !(wb_go && (wb_addr == ra));
      end
    end
  end

endmodule
